// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder constants: lifting factor, base-matrix limits and derived widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: LiftingFactor (QSN width), MaxRows/MaxDeg (base-matrix dimensions),
//           derived widths, and the syndrome-checker state enum.
package ldpc_pkg;

  localparam int LiftingFactor = 4;
  localparam int MaxRows       = 8;
  localparam int MaxDeg        = 8;

  localparam int RowIdxW = $clog2(MaxRows);
  localparam int CntW    = $clog2(MaxRows * LiftingFactor + 1);
  // Degree counter must be able to represent MaxDeg itself to detect a 9th beat.
  localparam int DegW    = $clog2(MaxDeg + 1);
  localparam int PopW    = $clog2(LiftingFactor + 1);

  typedef enum logic [0:0] {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } syn_state_t;

endpackage

// File: rtl/popcount_z.sv
// Combinational population count of a W-bit vector.
// Latency: 0 cycles (pure combinational).
// Backpressure: n/a.
// Ports: vec (W-bit input vector), count (number of set bits in vec).
module popcount_z #(
  parameter int W  = 4,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  vec,
  output logic [CW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/qsn_syndrome_check.sv
// XOR-accumulates rotated QSN vectors per base-matrix row into row syndromes and frame pass/fail.
// Latency: row/frame results 1 cycle after the accepting edge; next frame accepted 2 cycles after last beat.
// Backpressure: in_ready drops for one REPORT cycle after each frame; result pulses cannot be stalled.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_bits/in_last_row/in_last_frame beat input;
//        row_valid/row_syndrome/row_idx per-row result; frame_valid/frame_pass/frame_unsat/frame_overflow per frame.
module qsn_syndrome_check
  import ldpc_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LiftingFactor-1:0] in_bits,
  input  logic                     in_last_row,
  input  logic                     in_last_frame,
  output logic                     row_valid,
  output logic [LiftingFactor-1:0] row_syndrome,
  output logic [RowIdxW-1:0]       row_idx,
  output logic                     frame_valid,
  output logic                     frame_pass,
  output logic [CntW-1:0]          frame_unsat,
  output logic                     frame_overflow
);

  syn_state_t state, state_nxt;

  logic [LiftingFactor-1:0] acc;
  logic [LiftingFactor-1:0] row_syn;
  logic [DegW-1:0]          deg;
  logic [RowIdxW-1:0]       row_cnt;
  logic [CntW-1:0]          unsat;
  logic [CntW-1:0]          unsat_nxt;
  logic [CntW:0]            unsat_sum;
  logic [PopW-1:0]          row_pop;
  logic                     ovf;
  logic                     ovf_nxt;
  logic                     deg_ovf;
  logic                     row_ovf;
  logic                     accept;
  logic                     row_end;

  assign accept  = in_valid && in_ready;
  // A frame end always closes the current row.
  assign row_end = in_last_row || in_last_frame;
  assign row_syn = acc ^ in_bits;

  popcount_z #(
    .W  (LiftingFactor),
    .CW (PopW)
  ) u_popcount (
    .vec   (row_syn),
    .count (row_pop)
  );

  // One spare bit catches the carry; saturate instead of wrapping.
  assign unsat_sum = {1'b0, unsat} + (CntW+1)'(row_pop);
  assign unsat_nxt = unsat_sum[CntW] ? '1 : unsat_sum[CntW-1:0];

  // A beat arriving while deg already sits at MaxDeg is the (MaxDeg+1)th of the row.
  assign deg_ovf = (deg == DegW'(MaxDeg));
  // Closing the last allowed row without ending the frame guarantees a further
  // row will follow (rows are never empty), so the row limit is exceeded.
  assign row_ovf = row_end && !in_last_frame && (row_cnt == RowIdxW'(MaxRows - 1));
  assign ovf_nxt = ovf || deg_ovf || row_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (accept && in_last_frame) begin
          state_nxt = REPORT;
        end
      end
      REPORT: begin
        state_nxt = ACCUM;
      end
      default: begin
        state_nxt = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc            <= '0;
      deg            <= '0;
      row_cnt        <= '0;
      unsat          <= '0;
      ovf            <= 1'b0;
      row_valid      <= 1'b0;
      row_syndrome   <= '0;
      row_idx        <= '0;
      frame_valid    <= 1'b0;
      frame_pass     <= 1'b0;
      frame_unsat    <= '0;
      frame_overflow <= 1'b0;
    end else begin
      row_valid   <= 1'b0;
      frame_valid <= 1'b0;

      // Frame-scoped counters clear as the single REPORT cycle ends.
      if (state == REPORT) begin
        row_cnt <= '0;
        unsat   <= '0;
        ovf     <= 1'b0;
      end

      if (accept) begin
        ovf <= ovf_nxt;
        if (row_end) begin
          acc          <= '0;
          deg          <= '0;
          unsat        <= unsat_nxt;
          row_valid    <= 1'b1;
          row_syndrome <= row_syn;
          row_idx      <= row_cnt;
          // Hold at the last index so row_idx saturates instead of wrapping.
          if (row_cnt != RowIdxW'(MaxRows - 1)) begin
            row_cnt <= row_cnt + 1'b1;
          end
        end else begin
          acc <= row_syn;
          if (!deg_ovf) begin
            deg <= deg + 1'b1;
          end
        end

        if (in_last_frame) begin
          frame_valid    <= 1'b1;
          frame_unsat    <= unsat_nxt;
          frame_overflow <= ovf_nxt;
          frame_pass     <= (unsat_nxt == '0) && !ovf_nxt;
        end
      end
    end
  end

endmodule
